// File: rtl/ifft_pkg.sv
// Shared constants, state encoding and address bit-reversal for the 16-point IFFT datapath.
// Consumed by ifft_ram_ctrl, ifft_bitrev and the butterfly core.
package ifft_pkg;

  localparam int IFFT_ADDR_WIDTH = 4;
  localparam int IFFT_DEPTH      = 1 << IFFT_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_PROC   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  function automatic logic [IFFT_ADDR_WIDTH-1:0] bitrev(input logic [IFFT_ADDR_WIDTH-1:0] a);
    logic [IFFT_ADDR_WIDTH-1:0] r;
    for (int i = 0; i < IFFT_ADDR_WIDTH; i++) r[i] = a[IFFT_ADDR_WIDTH-1-i];
    return r;
  endfunction

endpackage

// File: rtl/ifft_bitrev.sv
// Combinational address bit-reverser; maps the linear unload count onto the
// in-place DIF result order. Instantiated only when IFFT_BITREV_UNLOAD_EN is defined.
module ifft_bitrev
  import ifft_pkg::*;
#(
  parameter int ADDR_WIDTH = IFFT_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
    assign addr_o[i] = addr_i[ADDR_WIDTH-1-i];
  end

endmodule

// File: rtl/ifft_ram_ctrl.sv
// Frame sequencer and RAM port arbiter for the IFFT working RAM: load, process, unload.
// Define IFFT_BITREV_UNLOAD_EN to unload in bit-reversed address order.
module ifft_ram_ctrl
  import ifft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = IFFT_ADDR_WIDTH,
  parameter int DEPTH      = IFFT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic                  core_wr_en,
  input  logic [ADDR_WIDTH-1:0] core_wr_add,
  input  logic [ADDR_WIDTH-1:0] core_rd_add,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_add,
  output logic [ADDR_WIDTH-1:0] ram_rd_add,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  core_start_q, core_start_d;
  logic                  frame_done_q, frame_done_d;
  logic [ADDR_WIDTH-1:0] unload_addr;
  logic                  load_fire;

`ifdef IFFT_BITREV_UNLOAD_EN
  ifft_bitrev #(.ADDR_WIDTH(ADDR_WIDTH)) u_bitrev (
    .addr_i (cnt_q),
    .addr_o (unload_addr)
  );
`else
  assign unload_addr = cnt_q;
`endif

  // in_ready is gated by rst so the upstream handshake is dead while reset is held.
  assign in_ready   = rst && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign load_fire  = in_ready && in_valid;
  assign busy       = (state_q != ST_IDLE);
  assign core_start = core_start_q;
  assign frame_done = frame_done_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
    frame_done_d = 1'b0;
    ram_wr_en    = 1'b0;
    ram_wr_add   = cnt_q;
    ram_rd_add   = '0;
    ram_wdata    = '0;
    out_valid    = 1'b0;
    out_data     = '0;

    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (load_fire) begin
          ram_wr_en = 1'b1;
          ram_wdata = in_data;
          cnt_d     = cnt_q + ADDR_WIDTH'(1);
          state_d   = ST_LOAD;
          if (cnt_q == CNT_LAST) begin
            state_d      = ST_PROC;
            core_start_d = 1'b1;
          end
        end
      end
      ST_PROC: begin
        ram_wr_en  = core_wr_en;
        ram_wr_add = core_wr_add;
        ram_rd_add = core_rd_add;
        if (core_done) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
        end
      end
      ST_UNLOAD: begin
        ram_rd_add = unload_addr;
        out_valid  = 1'b1;
        out_data   = ram_rdata;
        if (out_ready) begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == CNT_LAST) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
            cnt_d        = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and clear asynchronously; the RAM
  // contents are not reset, a frame is simply reloaded from address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_ifft_ram_ctrl.sv
// Directed self-checking bench for ifft_ram_ctrl with a behavioural RAM (combinational read).
// Expected unload order follows IFFT_BITREV_UNLOAD_EN.
module tb_ifft_ram_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        core_start, core_done, core_wr_en;
  logic [3:0]  core_wr_add, core_rd_add;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_add, ram_rd_add;
  logic [15:0] ram_wdata, ram_rdata;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        frame_done, busy;

  logic [15:0] mem [16];
  int          exp_addr [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  ifft_ram_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_wr_en  (core_wr_en),
    .core_wr_add (core_wr_add),
    .core_rd_add (core_rd_add),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_add  (ram_wr_add),
    .ram_rd_add  (ram_rd_add),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (ram_wr_en) mem[ram_wr_add] <= ram_wdata;
  assign ram_rdata = mem[ram_rd_add];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  in_ready,   0);
    check({tag, "_busy"},      busy,       0);
    check({tag, "_out_valid"}, out_valid,  0);
    check({tag, "_out_data"},  out_data,   0);
    check({tag, "_start"},     core_start, 0);
    check({tag, "_fdone"},     frame_done, 0);
    check({tag, "_wr_en"},     ram_wr_en,  0);
    check({tag, "_wr_add"},    ram_wr_add, 0);
    check({tag, "_rd_add"},    ram_rd_add, 0);
  endtask

  initial begin
    int k;
    int cyc;
`ifdef IFFT_BITREV_UNLOAD_EN
    exp_addr = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
    exp_addr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
    rst = 1'b0; in_valid = 1'b0; in_data = '0; core_done = 1'b0; core_wr_en = 1'b0;
    core_wr_add = '0; core_rd_add = '0; out_ready = 1'b0;

    // Reset state
    #2;
    check_all_zero("rst");
    step(); step();
    rst = 1'b1;
    #1;
    check("idle_ready", in_ready, 1);
    check("idle_busy",  busy,     0);

    // Frame 1: back-to-back load with core write requests that must be masked
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 1); core_wr_en = 1'b1; core_wr_add = 4'hF;
      #1;
      check("ld1_we",   ram_wr_en,  1);
      check("ld1_add",  ram_wr_add, i);
      check("ld1_data", ram_wdata,  i + 1);
      step();
    end
    in_valid = 1'b0; core_wr_en = 1'b0;
    #1;
    check("start_pulse", core_start, 1);
    check("proc_ready",  in_ready,   0);
    check("proc_busy",   busy,       1);
    step();
    check("start_once", core_start, 0);

    // PROC: RAM ports follow the core directly
    core_wr_add = 4'd5; core_rd_add = 4'd9; core_wr_en = 1'b1; in_valid = 1'b1;
    #1;
    check("mux_we",    ram_wr_en,  1);
    check("mux_wadd",  ram_wr_add, 5);
    check("mux_radd",  ram_rd_add, 9);
    check("mux_ready", in_ready,   0);
    core_wr_en = 1'b0; in_valid = 1'b0;
    #1;
    check("mux_we_off", ram_wr_en, 0);
    step();
    repeat (37) step();
    core_done = 1'b1;
    #1;
    check("proc_no_out", out_valid, 0);
    step();
    core_done = 1'b0;

    // Frame 1 unload, stalled at beat 3, core write requests masked
    core_wr_en = 1'b1; out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      if (b == 3) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          check("hold_valid", out_valid,  1);
          check("hold_radd",  ram_rd_add, exp_addr[3]);
          check("hold_data",  out_data,   exp_addr[3] + 1);
          step();
        end
        out_ready = 1'b1;
      end
      #1;
      check("ul1_valid", out_valid,  1);
      check("ul1_we",    ram_wr_en,  0);
      check("ul1_radd",  ram_rd_add, exp_addr[b]);
      check("ul1_data",  out_data,   exp_addr[b] + 1);
      check("ul1_fdone", frame_done, 0);
      step();
    end
    core_wr_en = 1'b0; out_ready = 1'b0;
    #1;
    check("fdone_pulse", frame_done, 1);
    check("fdone_busy",  busy,       0);
    check("fdone_valid", out_valid,  0);
    check("fdone_data",  out_data,   0);
    check("fdone_ready", in_ready,   1);
    step();
    check("fdone_once", frame_done, 0);

    // Frame 2: in_valid toggling every other cycle
    k = 0; cyc = 0;
    while (k < 16 && cyc < 64) begin
      in_valid = (cyc % 2 == 0); in_data = 16'(16'h0100 + k);
      #1;
      check("ld2_we", ram_wr_en, in_valid);
      if (in_valid) begin
        check("ld2_add", ram_wr_add, k);
        k++;
      end
      step();
      cyc++;
    end
    check("ld2_count", k, 16);
    in_valid = 1'b0;

    // core_done coincident with core_start
    core_done = 1'b1;
    #1;
    check("ld2_start", core_start, 1);
    step();
    core_done = 1'b0;
    #1;
    check("ul2_valid", out_valid,  1);
    check("ul2_radd0", ram_rd_add, 0);
    check("ul2_data0", out_data,   16'h0100);
    out_ready = 1'b1;
    step();
    check("ul2_radd1", ram_rd_add, exp_addr[1]);
    check("ul2_data1", out_data,   16'h0100 + exp_addr[1]);
    step();

    // Reset mid-UNLOAD
    rst = 1'b0; in_valid = 1'b1; core_wr_en = 1'b1;
    #1;
    check_all_zero("rst_ul");
    step();
    rst = 1'b1; in_valid = 1'b0; core_wr_en = 1'b0; out_ready = 1'b0;

    // Frame 3: full load restarts at address 0, then reset mid-PROC
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0200 + i);
      #1;
      check("ld3_add", ram_wr_add, i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("ld3_proc_busy", busy, 1);
    core_wr_en = 1'b1; core_wr_add = 4'd7; core_rd_add = 4'd7;
    rst = 1'b0;
    #1;
    check_all_zero("rst_proc");
    step();
    rst = 1'b1; core_wr_en = 1'b0;

    // Frame 4 starts cleanly at address 0
    in_valid = 1'b1; in_data = 16'h03AA;
    #1;
    check("ld4_we",  ram_wr_en,  1);
    check("ld4_add", ram_wr_add, 0);
    step();
    in_valid = 1'b0;
    #1;
    check("ld4_busy",  busy,     1);
    check("ld4_ready", in_ready, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
